alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Sequences one operation at a time through an external 4-bit ALU:
// latch the request, prime the ALU with a toggled control code, execute, then hold the result.
// Optional res_zero output is enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_op_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic       in_cin,
    input  logic [2:0] in_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic [2:0] alu_ctrl,
    input  logic [3:0] alu_out,
    input  logic       alu_cout,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_cout,
    output logic       busy,
    output logic [7:0] op_count
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,output logic      res_zero
`endif
);

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        EXEC   = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_cin;
    logic [OP_W-1:0]     r_op;
    logic                w_accept;
    logic                w_arith;

    assign w_accept = in_valid & in_ready;
    // Only add/subtract produce a meaningful carry/borrow.
    assign w_arith  = (r_op == OP_W'(0)) || (r_op == OP_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_cin     <= 1'b0;
            r_op      <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cout  <= 1'b0;
            op_count  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cin   <= 1'b0;
            alu_ctrl  <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            res_zero  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= in_a;
                        r_b      <= in_b;
                        r_cin    <= in_cin;
                        r_op     <= in_op;
                        alu_a    <= in_a;
                        alu_b    <= in_b;
                        alu_cin  <= in_cin;
                        // Toggled code guarantees the ALU sees a control change even for repeated ops.
                        alu_ctrl <= in_op ^ OP_W'(1);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= PRIME;
                    end
                end
                PRIME: begin
                    alu_a    <= r_a;
                    alu_b    <= r_b;
                    alu_cin  <= r_cin;
                    alu_ctrl <= r_op;
                    r_state  <= EXEC;
                end
                EXEC: begin
                    res_data  <= alu_out;
                    res_cout  <= w_arith ? alu_cout : 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    res_zero  <= (alu_out == DATA_W'(0));
`endif
                    res_valid <= 1'b1;
                    r_state   <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural 4-bit ALU model.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_cin;
    logic [2:0] in_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic [2:0] alu_ctrl;
    logic [3:0] alu_out;
    logic       alu_cout;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_cout;
    logic       busy;
    logic [7:0] op_count;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic       res_zero;
`endif

    typedef struct packed {
        logic [3:0] d;
        logic       c;
        logic       z;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         last_wait;
    logic [7:0] exp_cnt = 8'h00;

    alu_op_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cout(res_cout),
        .busy(busy), .op_count(op_count)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        , .res_zero(res_zero)
`endif
    );

    always #5 clk = ~clk;

    // ALU model: 000 add, 001 subtract with borrow, 010 OR, 011 AND, else XOR.
    // Logic ops drive cout=1 so the sequencer's carry masking is observable.
    always_comb begin
        case (alu_ctrl)
            3'b000:  {alu_cout, alu_out} = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);
            3'b001:  {alu_cout, alu_out} = 5'(alu_a) - 5'(alu_b) - 5'(alu_cin);
            3'b010:  {alu_cout, alu_out} = {1'b1, alu_a | alu_b};
            3'b011:  {alu_cout, alu_out} = {1'b1, alu_a & alu_b};
            default: {alu_cout, alu_out} = {1'b1, alu_a ^ alu_b};
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every handshaken result against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got data %0h with no expected entry at %0t", res_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("res_data", int'(res_data), int'(e.d));
                    chk("res_cout", int'(res_cout), int'(e.c));
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    chk("res_zero", int'(res_zero), int'(e.z));
`endif
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  int'(in_ready), 1);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_res_data"},  int'(res_data), 0);
        chk({tag, "_res_cout"},  int'(res_cout), 0);
        chk({tag, "_op_count"},  int'(op_count), 0);
        chk({tag, "_alu_ops"},   int'({alu_a, alu_b, alu_cin}), 0);
        chk({tag, "_alu_ctrl"},  int'(alu_ctrl), 0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        chk({tag, "_res_zero"},  int'(res_zero), 0);
`endif
    endtask

    // Issue one request; called just after a rising edge. Returns just after the edge
    // that leaves RESULT (res_ready=1) or just after res_valid rises (res_ready=0).
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic [2:0] op, input logic [3:0] d, input logic c, input logic z);
        int   n;
        logic ok;
        exp_t e;
        e.d = d; e.c = c; e.z = z;
        sb.push_back(e);
        in_a = a; in_b = b; in_cin = cin; in_op = op; in_valid = 1'b1;
        n = 0;
        do begin
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 20);
        last_wait = n;
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready still %0d after %0d cycles", in_ready, n);
        end
        chk("prime_ctrl", int'(alu_ctrl), int'(op ^ 3'b001));
        chk("prime_ops",  int'({alu_a, alu_b, alu_cin}), int'({a, b, cin}));
        chk("prime_busy", int'({busy, in_ready}), 2);
        @(posedge clk); #1;
        chk("exec_ctrl",  int'(alu_ctrl), int'(op));
        chk("exec_valid", int'(res_valid), 0);
        @(posedge clk); #1;
        chk("latency_valid", int'(res_valid), 1);
        chk("result_ready",  int'(in_ready), 0);
        if (res_ready) begin
            exp_cnt++;
            @(posedge clk); #1;
            chk("op_count", int'(op_count), int'(exp_cnt));
            chk("idle_flags", int'({busy, in_ready, res_valid}), 2);
        end
    endtask

    initial begin
        int total;
        rst = 1'b1; in_valid = 1'b0; in_a = 4'h0; in_b = 4'h0; in_cin = 1'b0;
        in_op = 3'b000; res_ready = 1'b1;
        #1;
        chk_reset_vals("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // Abort an operation with reset during EXEC: nothing may be presented.
        @(posedge clk); #1;
        in_a = 4'h7; in_b = 4'h5; in_cin = 1'b1; in_op = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_exec", int'(alu_ctrl), 0);
        rst = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic add, accepted on the first edge after reset release.
        do_op(4'h7, 4'h5, 1'b1, 3'b000, 4'hD, 1'b0, 1'b0);
        chk("first_accept_wait", last_wait, 1);
        chk("op_count_one", int'(op_count), 1);
        do_op(4'hF, 4'h1, 1'b0, 3'b000, 4'h0, 1'b1, 1'b1);
        do_op(4'h3, 4'h5, 1'b0, 3'b001, 4'hE, 1'b1, 1'b0);
        // Back-to-back identical AND ops; carry must be masked.
        do_op(4'hC, 4'hA, 1'b0, 3'b011, 4'h8, 1'b0, 1'b0);
        do_op(4'h3, 4'h5, 1'b0, 3'b011, 4'h1, 1'b0, 1'b0);
        chk("b2b_wait", last_wait, 1);

        // Backpressure: result holds, new requests ignored.
        res_ready = 1'b0;
        do_op(4'h1, 4'h2, 1'b0, 3'b010, 4'h3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0) && (i < 4);
            in_a = 4'h9; in_b = 4'h6; in_op = 3'b100;
            chk("stall_valid", int'(res_valid), 1);
            chk("stall_data",  int'(res_data), 3);
            chk("stall_ready", int'(in_ready), 0);
            chk("stall_alu_a", int'(alu_a), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        chk("release_idle", int'({busy, in_ready, res_valid}), 2);
        chk("release_count", int'(op_count), int'(exp_cnt));
        @(posedge clk); #1;
        chk("ignored_req", int'(busy), 0);

        do_op(4'h5, 4'hA, 1'b0, 3'b011, 4'h0, 1'b0, 1'b1);

        // Complete ops until 256 total so op_count wraps.
        total = 7;
        for (int i = 0; total < 256; i++) begin
            do_op(4'(i), 4'h0, 1'b0, 3'b010, 4'(i), 1'b0, (4'(i) == 4'h0));
            total++;
        end
        chk("wrap_count", int'(op_count), 0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
